player_ground_collider: RTL and testbench

//  Produces the ground-collision inputs consumed by the player position controller.
//  On each scan_start it walks the platform table and returns the highest platform top
//  at or below the player's feet that overlaps the player horizontally.

---
 rtl/player_ground_collider.sv | 196 +++++++++++++++++++
 tb/tb_player_ground_collider.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_ground_collider.sv
// Scans the platform table on request and returns the highest ground platform under the player.
// Optional ceiling search is compiled in with GROUND_COLLIDER_CEILING_EN.
module player_ground_collider #(
  parameter int MAX_PLATFORMS = 8,
  parameter int ADDR_W        = 3,
  parameter int SNAP_MARGIN   = 2,
  parameter int STEP_TOL      = 0
) (
  input  logic              clk_player_control,
  input  logic              reset_n,
  input  logic              scan_start,
  input  logic [9:0]        player_pos_x,
  input  logic [9:0]        player_pos_y,
  input  logic [9:0]        player_w,
  input  logic [9:0]        player_h,
  output logic              platform_rd,
  output logic [ADDR_W-1:0] platform_addr,
  input  logic              platform_active,
  input  logic [9:0]        platform_x0,
  input  logic [9:0]        platform_x1,
  input  logic [9:0]        platform_y0,
  input  logic [9:0]        platform_y1,
  output logic [9:0]        collider_ground_h_player,
  output logic              is_collider_ground_player,
  output logic              scan_busy,
  output logic              scan_done
`ifdef GROUND_COLLIDER_CEILING_EN
  ,
  output logic [9:0]        collider_ceiling_h_player,
  output logic [0:0]        is_collider_ceiling_player
`endif
);

  // state   | meaning
  // S_IDLE  | waiting for scan_start
  // S_SCAN  | issuing table reads 0..MAX_PLATFORMS-1
  // S_DRAIN | evaluating the last returned entry
  // S_DONE  | results published, scan_done pulse
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_PLATFORMS - 1);
  localparam logic [10:0]       SNAP_W    = 11'(SNAP_MARGIN);
  localparam logic [10:0]       TOL_W     = 11'(STEP_TOL);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              eval_q;
  logic [9:0]        px_q, px_d, pw_q, pw_d;
  logic [10:0]       feet_q, feet_d;
  logic              gnd_found_q, gnd_found_d;
  logic [9:0]        gnd_h_q, gnd_h_d;
  logic              res_gnd_found_q, res_gnd_found_d;
  logic [9:0]        res_gnd_h_q, res_gnd_h_d;
  logic              overlap, gnd_take;

  // Sums widened to 11 bits so edges near 1023 never wrap.
  assign overlap = (platform_x0 < platform_x1)
                && ({1'b0, px_q} < {1'b0, platform_x1})
                && (({1'b0, px_q} + {1'b0, pw_q}) > {1'b0, platform_x0});
  assign gnd_take = eval_q && platform_active && overlap
                 && (({1'b0, platform_y0} + TOL_W) >= feet_q)
                 && (!gnd_found_q || (platform_y0 < gnd_h_q));

`ifdef GROUND_COLLIDER_CEILING_EN
  logic [9:0] py_q, py_d;
  logic       ceil_found_q, ceil_found_d;
  logic [9:0] ceil_h_q, ceil_h_d;
  logic       res_ceil_found_q, res_ceil_found_d;
  logic [9:0] res_ceil_h_q, res_ceil_h_d;
  logic       ceil_take;

  assign ceil_take = eval_q && platform_active && overlap
                  && (platform_y1 <= py_q)
                  && (!ceil_found_q || (platform_y1 > ceil_h_q));
`else
  logic unused_y1;
  assign unused_y1 = ^platform_y1;
`endif

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    px_d            = px_q;
    pw_d            = pw_q;
    feet_d          = feet_q;
    gnd_found_d     = gnd_found_q;
    gnd_h_d         = gnd_h_q;
    res_gnd_found_d = res_gnd_found_q;
    res_gnd_h_d     = res_gnd_h_q;
`ifdef GROUND_COLLIDER_CEILING_EN
    py_d             = py_q;
    ceil_found_d     = ceil_found_q;
    ceil_h_d         = ceil_h_q;
    res_ceil_found_d = res_ceil_found_q;
    res_ceil_h_d     = res_ceil_h_q;
    if (ceil_take) begin
      ceil_found_d = 1'b1;
      ceil_h_d     = platform_y1;
    end
`endif
    if (gnd_take) begin
      gnd_found_d = 1'b1;
      gnd_h_d     = platform_y0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (scan_start) begin
          state_d     = S_SCAN;
          addr_d      = '0;
          px_d        = player_pos_x;
          pw_d        = player_w;
          feet_d      = {1'b0, player_pos_y} + {1'b0, player_h} - SNAP_W;
          gnd_found_d = 1'b0;
          gnd_h_d     = '0;
`ifdef GROUND_COLLIDER_CEILING_EN
          py_d         = player_pos_y;
          ceil_found_d = 1'b0;
          ceil_h_d     = '0;
`endif
        end
      end
      S_SCAN: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end
      end
      S_DRAIN: begin
        // Publish includes the last entry, evaluated this cycle.
        state_d         = S_DONE;
        res_gnd_found_d = gnd_found_d;
        res_gnd_h_d     = gnd_found_d ? gnd_h_d : 10'd0;
`ifdef GROUND_COLLIDER_CEILING_EN
        res_ceil_found_d = ceil_found_d;
        res_ceil_h_d     = ceil_found_d ? ceil_h_d : 10'd0;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_player_control or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      eval_q          <= 1'b0;
      px_q            <= '0;
      pw_q            <= '0;
      feet_q          <= '0;
      gnd_found_q     <= 1'b0;
      gnd_h_q         <= '0;
      res_gnd_found_q <= 1'b0;
      res_gnd_h_q     <= '0;
`ifdef GROUND_COLLIDER_CEILING_EN
      py_q             <= '0;
      ceil_found_q     <= 1'b0;
      ceil_h_q         <= '0;
      res_ceil_found_q <= 1'b0;
      res_ceil_h_q     <= '0;
`endif
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      eval_q          <= platform_rd;
      px_q            <= px_d;
      pw_q            <= pw_d;
      feet_q          <= feet_d;
      gnd_found_q     <= gnd_found_d;
      gnd_h_q         <= gnd_h_d;
      res_gnd_found_q <= res_gnd_found_d;
      res_gnd_h_q     <= res_gnd_h_d;
`ifdef GROUND_COLLIDER_CEILING_EN
      py_q             <= py_d;
      ceil_found_q     <= ceil_found_d;
      ceil_h_q         <= ceil_h_d;
      res_ceil_found_q <= res_ceil_found_d;
      res_ceil_h_q     <= res_ceil_h_d;
`endif
    end
  end

  assign platform_rd               = (state_q == S_SCAN);
  assign platform_addr             = addr_q;
  assign scan_busy                 = (state_q != S_IDLE);
  assign scan_done                 = (state_q == S_DONE);
  assign collider_ground_h_player  = res_gnd_h_q;
  assign is_collider_ground_player = res_gnd_found_q;
`ifdef GROUND_COLLIDER_CEILING_EN
  assign collider_ceiling_h_player  = res_ceil_h_q;
  assign is_collider_ceiling_player = res_ceil_found_q;
`endif

endmodule

// File: tb/tb_player_ground_collider.sv
// Randomized and directed bench for player_ground_collider against a table-walk reference model.
module tb_player_ground_collider;

  localparam int NP = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scan_start;
  logic [9:0] px, py, pw, ph;
  logic       rd, rd2;
  logic [2:0] addr, addr2;
  logic       act;
  logic [9:0] x0, x1, y0, y1;
  logic [9:0] gh, gh2;
  logic       gis, gis2, busy, busy2, done, done2;
`ifdef GROUND_COLLIDER_CEILING_EN
  logic [9:0] ch, ch2;
  logic [0:0] cis, cis2;
`endif

  logic [9:0] t_x0 [NP];
  logic [9:0] t_x1 [NP];
  logic [9:0] t_y0 [NP];
  logic [9:0] t_y1 [NP];
  logic       t_act[NP];

  int total = 0;
  int bad   = 0;
  int prev_h = 0;
  int prev_f = 0;

  always #5 clk = ~clk;

  player_ground_collider dut (
    .clk_player_control(clk), .reset_n(rst_n), .scan_start(scan_start),
    .player_pos_x(px), .player_pos_y(py), .player_w(pw), .player_h(ph),
    .platform_rd(rd), .platform_addr(addr), .platform_active(act),
    .platform_x0(x0), .platform_x1(x1), .platform_y0(y0), .platform_y1(y1),
    .collider_ground_h_player(gh), .is_collider_ground_player(gis),
    .scan_busy(busy), .scan_done(done)
`ifdef GROUND_COLLIDER_CEILING_EN
    , .collider_ceiling_h_player(ch), .is_collider_ceiling_player(cis)
`endif
  );

  player_ground_collider #(.STEP_TOL(20)) dut_tol (
    .clk_player_control(clk), .reset_n(rst_n), .scan_start(scan_start),
    .player_pos_x(px), .player_pos_y(py), .player_w(pw), .player_h(ph),
    .platform_rd(rd2), .platform_addr(addr2), .platform_active(act),
    .platform_x0(x0), .platform_x1(x1), .platform_y0(y0), .platform_y1(y1),
    .collider_ground_h_player(gh2), .is_collider_ground_player(gis2),
    .scan_busy(busy2), .scan_done(done2)
`ifdef GROUND_COLLIDER_CEILING_EN
    , .collider_ceiling_h_player(ch2), .is_collider_ceiling_player(cis2)
`endif
  );

  // Synchronous table: data for a read appears the following cycle; junk otherwise.
  always @(posedge clk) begin
    if (rd) begin
      act <= t_act[addr];
      x0  <= t_x0[addr];
      x1  <= t_x1[addr];
      y0  <= t_y0[addr];
      y1  <= t_y1[addr];
    end else begin
      act <= 1'($urandom_range(1, 0));
      x0  <= 10'($urandom_range(1023, 0));
      x1  <= 10'($urandom_range(1023, 0));
      y0  <= 10'($urandom_range(1023, 0));
      y1  <= 10'($urandom_range(1023, 0));
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit hits(input int i, input int sx, input int sw);
    return t_act[i] && (t_x0[i] < t_x1[i]) && (sx < int'(t_x1[i])) && (sx + sw > int'(t_x0[i]));
  endfunction

  // Highest ground top at or below feet (smallest y0) among overlapping active entries.
  task automatic model_ground(input int tol, input int sx, input int sy, input int sw, input int sh,
                              output int f, output int h);
    int feet;
    feet = sy + sh - 2;
    f = 0;
    h = 0;
    for (int i = 0; i < NP; i++)
      if (hits(i, sx, sw) && int'(t_y0[i]) + tol >= feet)
        if (f == 0 || int'(t_y0[i]) < h) begin
          f = 1;
          h = int'(t_y0[i]);
        end
  endtask

  task automatic model_ceiling(input int sx, input int sy, input int sw, output int f, output int h);
    f = 0;
    h = 0;
    for (int i = 0; i < NP; i++)
      if (hits(i, sx, sw) && int'(t_y1[i]) <= sy)
        if (f == 0 || int'(t_y1[i]) > h) begin
          f = 1;
          h = int'(t_y1[i]);
        end
  endtask

  task automatic clear_table();
    for (int i = 0; i < NP; i++) begin
      t_act[i] = 1'b0;
      t_x0[i]  = 10'd0;
      t_x1[i]  = 10'd0;
      t_y0[i]  = 10'd0;
      t_y1[i]  = 10'd0;
    end
  endtask

  task automatic set_ent(input int i, input int a0, input int a1, input int b0, input int b1);
    t_act[i] = 1'b1;
    t_x0[i]  = 10'(a0);
    t_x1[i]  = 10'(a1);
    t_y0[i]  = 10'(b0);
    t_y1[i]  = 10'(b1);
  endtask

  task automatic set_player(input int x, input int y, input int w, input int h);
    px = 10'(x);
    py = 10'(y);
    pw = 10'(w);
    ph = 10'(h);
  endtask

  // One scan; perturb scrambles player inputs after the snapshot, restart pulses scan_start at +3.
  task automatic run_scan(input string tag, input bit perturb, input bit restart);
    int ef, eh, ef2, eh2, lat, extra;
    int sx, sy, sw, sh;
`ifdef GROUND_COLLIDER_CEILING_EN
    int cf, chx;
`endif
    sx = int'(px); sy = int'(py); sw = int'(pw); sh = int'(ph);
    model_ground(0, sx, sy, sw, sh, ef, eh);
    model_ground(20, sx, sy, sw, sh, ef2, eh2);
`ifdef GROUND_COLLIDER_CEILING_EN
    model_ceiling(sx, sy, sw, cf, chx);
`endif
    @(negedge clk);
    scan_start = 1'b1;
    lat = 0;
    for (int c = 1; c <= NP + 8 && lat == 0; c++) begin
      @(negedge clk);
      scan_start = restart && (c == 3);
      if (c == 1) check({tag, "_busy"}, int'(busy), 1);
      if (c == 5) check({tag, "_hold"}, int'(gh) * 2 + int'(gis), prev_h * 2 + prev_f);
      if (perturb) set_player($urandom_range(1023, 0), $urandom_range(1023, 0),
                              $urandom_range(1023, 0), $urandom_range(1023, 0));
      if (done) lat = c;
    end
    scan_start = 1'b0;
    check({tag, "_latency"}, lat, NP + 2);
    check({tag, "_is"}, int'(gis), ef);
    check({tag, "_h"}, int'(gh), eh);
    check({tag, "_tol_is"}, int'(gis2), ef2);
    check({tag, "_tol_h"}, int'(gh2), eh2);
`ifdef GROUND_COLLIDER_CEILING_EN
    check({tag, "_ceil_is"}, int'(cis), cf);
    check({tag, "_ceil_h"}, int'(ch), chx);
`endif
    prev_f = ef;
    prev_h = eh;
    extra = 0;
    for (int c = 0; c < (restart ? 12 : 1); c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({tag, "_no_extra_done"}, extra, 0);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic abort_scan(input string tag, input int at);
    int dones;
    @(negedge clk);
    scan_start = 1'b1;
    for (int c = 1; c <= at; c++) begin
      @(negedge clk);
      scan_start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_rd"}, int'(rd), 0);
    check({tag, "_rst_out"}, int'(gh) + int'(gis) + int'(busy) + int'(done) + int'(addr), 0);
`ifdef GROUND_COLLIDER_CEILING_EN
    check({tag, "_rst_ceil"}, int'(ch) + int'(cis), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < NP + 6; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check({tag, "_no_done"}, dones, 0);
    check({tag, "_out_zero"}, int'(gh) + int'(gis), 0);
    prev_f = 0;
    prev_h = 0;
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
  endfunction

  initial begin
    int dones, x, y, w, h, feet, base;
    rst_n = 1'b0;
    scan_start = 1'b0;
    set_player(0, 0, 0, 0);
    clear_table();
    repeat (3) @(negedge clk);
    check("reset_out", int'(gh) + int'(gis) + int'(busy) + int'(done) + int'(rd), 0);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("reset_no_done", dones, 0);

    set_ent(0, 300, 400, 300, 100);
    set_player(320, 240, 30, 30);
    run_scan("t2", 0, 0);
    check("t2_h_const", int'(gh), 300);

    set_ent(1, 310, 420, 280, 90);
    run_scan("t3a", 0, 0);
    set_ent(2, 300, 400, 250, 80);
    run_scan("t3b", 0, 0);
    check("t3b_h_const", int'(gh), 280);
    check("t3b_tol_h_const", int'(gh2), 250);

    clear_table();
    set_ent(0, 350, 450, 300, 100);
    set_player(320, 240, 30, 30);
    run_scan("t4_touch", 0, 0);
    set_player(321, 240, 30, 30);
    run_scan("t4_over", 0, 0);
    set_player(400, 240, 30, 30);
    run_scan("t4_right", 0, 0);
    clear_table();
    set_ent(0, 330, 330, 280, 100);
    set_player(300, 240, 60, 30);
    run_scan("t4_degen", 0, 0);

    clear_table();
    set_ent(3, 300, 400, 300, 100);
    set_ent(5, 310, 330, 270, 100);
    set_player(320, 240, 30, 30);
    run_scan("t5_restart", 1, 1);
    abort_scan("t1_abort", 3);
    run_scan("t5_pre", 0, 0);
    abort_scan("t5_abort", 5);

    clear_table();
    set_ent(0, 300, 400, 100, 200);
    set_player(320, 240, 30, 30);
    run_scan("t6_ceil", 0, 0);
    set_player(320, 199, 30, 30);
    run_scan("t6_noceil", 0, 0);

    for (int n = 0; n < 40; n++) begin
      x = $urandom_range(900, 0);
      y = $urandom_range(800, 0);
      w = $urandom_range(120, 1);
      h = $urandom_range(150, 2);
      feet = y + h - 2;
      set_player(x, y, w, h);
      for (int i = 0; i < NP; i++) begin
        base = x + $urandom_range(250, 0) - 150;
        t_act[i] = ($urandom_range(7, 0) != 0);
        t_x0[i]  = 10'(clamp(base));
        t_x1[i]  = 10'(clamp(base + $urandom_range(200, 0) - 20));
        t_y0[i]  = 10'(clamp(feet + $urandom_range(160, 0) - 60));
        t_y1[i]  = 10'(clamp(y + $urandom_range(120, 0) - 100));
      end
      run_scan("rand", n[0], n % 5 == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
